// File: rtl/glitch_report_tx.sv
// Measures target response latency after a glitch and streams an 8-byte report
// frame (header, seq, width, status, latency, checksum) to a byte-wide UART core.
module glitch_report_tx #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        glitch_done,
    input  logic [15:0] glitch_width,
    input  logic        target_ok,
    input  logic        tx_busy,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic [7:0]  seq
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MEASURE   = 3'd1,
        LOAD      = 3'd2,
        STROBE    = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [15:0] width_q, width_d;
    logic [15:0] lat_q, lat_d;
    logic        ovr_q, ovr_d;
    logic        ok_q, ok_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        transmit_q, transmit_d;
    logic        busy_q, busy_d;

    logic        ok_s;
    logic [7:0]  cur_byte;

    assign ok_s = sync_q[1];

    always_comb begin
        unique case (idx_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = seq_q;
            3'd2:    cur_byte = width_q[15:8];
            3'd3:    cur_byte = width_q[7:0];
            3'd4:    cur_byte = {ovr_q, 6'b0, ok_q};
            3'd5:    cur_byte = lat_q[15:8];
            3'd6:    cur_byte = lat_q[7:0];
            default: cur_byte = csum_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[0], target_ok};
        width_d   = width_q;
        lat_d     = lat_q;
        ovr_d     = ovr_q;
        ok_d      = ok_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        csum_d    = csum_q;
        tx_byte_d = tx_byte_q;

        // A glitch arriving mid-frame is only flagged; once the status byte
        // has gone out the flag no longer reaches the wire.
        if (glitch_done && state_q != IDLE)
            ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (glitch_done) begin
                    width_d = glitch_width;
                    lat_d   = 16'd0;
                    ovr_d   = 1'b0;
                    ok_d    = 1'b0;
                    csum_d  = 8'd0;
                    idx_d   = 3'd0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (ok_s) begin
                    ok_d    = 1'b1;
                    state_d = LOAD;
                end else if (lat_q == TIMEOUT) begin
                    ok_d    = 1'b0;
                    state_d = LOAD;
                end else begin
                    lat_d = lat_q + 16'd1;
                end
            end
            LOAD: begin
                tx_byte_d = cur_byte;
                if (idx_q != 3'd0 && idx_q != 3'd7)
                    csum_d = csum_q ^ cur_byte;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end else begin
                        idx_d   = 3'd0;
                        seq_d   = seq_q + 8'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        transmit_d = (state_d == STROBE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= 2'b00;
            width_q    <= 16'd0;
            lat_q      <= 16'd0;
            ovr_q      <= 1'b0;
            ok_q       <= 1'b0;
            idx_q      <= 3'd0;
            seq_q      <= 8'd0;
            csum_q     <= 8'd0;
            tx_byte_q  <= 8'd0;
            transmit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            width_q    <= width_d;
            lat_q      <= lat_d;
            ovr_q      <= ovr_d;
            ok_q       <= ok_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
            busy_q     <= busy_d;
        end
    end

    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
    assign busy     = busy_q;
    assign seq      = seq_q;

endmodule

// File: tb/tb_glitch_report_tx.sv
// Directed bench for glitch_report_tx: a UART model captures strobed bytes and
// each frame is compared against hand-computed bytes.
module tb_glitch_report_tx;

    logic        clk;
    logic        rst_n;
    logic        glitch_done;
    logic [15:0] glitch_width;
    logic        target_ok;
    logic        tx_busy;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [7:0]  seq;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  rxq[$];
    int          ucnt    = 0;
    int          strobes = 0;
    int          viol    = 0;
    logic        prev_tx = 1'b0;
    logic [7:0]  last_b  = 8'd0;
    logic [63:0] got;

    glitch_report_tx #(.HEADER(8'hA5), .TIMEOUT(16'd50)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .glitch_done  (glitch_done),
        .glitch_width (glitch_width),
        .target_ok    (target_ok),
        .tx_busy      (tx_busy),
        .transmit     (transmit),
        .tx_byte      (tx_byte),
        .busy         (busy),
        .seq          (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy rises 2 cycles after the strobe and lasts 10 cycles.
    always @(posedge clk) begin
        if (transmit) begin
            rxq.push_back(tx_byte);
            ucnt <= 12;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
        end
    end
    assign tx_busy = (ucnt != 0) && (ucnt <= 10);

    // Protocol watch: no back-to-back strobes, no strobe while busy, byte held.
    always @(negedge clk) begin
        if (transmit) begin
            strobes <= strobes + 1;
            last_b  <= tx_byte;
        end
        viol <= viol + int'(transmit && (prev_tx || tx_busy))
                     + int'(rst_n && tx_busy && !transmit && (tx_byte !== last_b));
        prev_tx <= transmit;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input string tag, input int n);
        int c = 0;
        while (rxq.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) check({tag, "_rx_timeout"}, 64'(rxq.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy !== 1'b0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic pop_frame(output logic [63:0] f);
        logic [7:0] b;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            b = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
            f = {f[55:0], b};
        end
    endtask

    task automatic collect(input string tag, output logic [63:0] f);
        wait_rx(tag, 8);
        wait_idle(tag);
        pop_frame(f);
    endtask

    // target_ok rises j edges after the edge that samples glitch_done
    // (j < 0: never), which measures as latency j+2.
    task automatic run_start(input logic [15:0] w, input int j);
        target_ok = 1'b0;
        repeat (4) @(posedge clk);
        #1 glitch_done = 1'b1;
        glitch_width = w;
        @(posedge clk);
        #1 glitch_done = 1'b0;
        if (j >= 0) begin
            repeat (j) @(posedge clk);
            if (j > 0) #1;
            target_ok = 1'b1;
        end
    endtask

    task automatic pulse_glitch(input logic [15:0] w);
        @(posedge clk);
        #1 glitch_done = 1'b1;
        glitch_width = w;
        @(posedge clk);
        #1 glitch_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        glitch_done = 1'b0;
        glitch_width = 16'd0;
        target_ok = 1'b0;
        #3;
        check("rst_transmit", 64'(transmit), 64'd0);
        check("rst_tx_byte",  64'(tx_byte),  64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_seq",      64'(seq),      64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Response after 40 cycles -> latency 42
        run_start(16'h1234, 40);
        check("main_busy", 64'(busy), 64'd1);
        collect("main", got);
        check("main_frame", got, 64'hA5001234_01002A0D);
        check("main_seq", 64'(seq), 64'd1);

        run_start(16'h1234, -1);
        collect("timeout", got);
        check("timeout_frame", got, 64'hA5011234_00003215);

        run_start(16'hBEEF, 0);
        collect("ok_early", got);
        check("ok_early_frame", got, 64'hA502BEEF_01000250);

        // ok_s arrives in the same cycle latency reaches TIMEOUT: success wins
        run_start(16'h0001, 48);
        collect("edge_to", got);
        check("edge_to_frame", got, 64'hA5030001_01003231);

        run_start(16'h00FF, 0);
        wait_rx("ovr_b2", 3);
        pulse_glitch(16'hDEAD);
        collect("ovr_b2", got);
        check("ovr_b2_frame", got, 64'hA50400FF_81000278);
        repeat (150) @(posedge clk);
        #1;
        check("ovr_b2_no_frame", 64'(rxq.size()), 64'd0);
        check("ovr_b2_seq", 64'(seq), 64'd5);

        run_start(16'h5555, 0);
        wait_rx("ovr_b5", 6);
        pulse_glitch(16'hDEAD);
        collect("ovr_b5", got);
        check("ovr_b5_frame", got, 64'hA5055555_01000206);
        repeat (150) @(posedge clk);
        #1;
        check("ovr_b5_no_frame", 64'(rxq.size()), 64'd0);

        // glitch_done sampled on the edge that returns the FSM to IDLE
        run_start(16'h0F0F, 0);
        wait_rx("ret_idle", 8);
        repeat (12) @(posedge clk);
        #1;
        check("ret_idle_pre_busy", 64'(busy), 64'd1);
        glitch_done = 1'b1;
        glitch_width = 16'hDEAD;
        @(posedge clk);
        #1 glitch_done = 1'b0;
        check("ret_idle_busy", 64'(busy), 64'd0);
        pop_frame(got);
        check("ret_idle_frame", got, 64'hA5060F0F_01000205);
        repeat (150) @(posedge clk);
        #1;
        check("ret_idle_no_frame", 64'(rxq.size()), 64'd0);
        check("ret_idle_seq", 64'(seq), 64'd7);

        // Reset in the middle of byte 5
        run_start(16'h7777, 0);
        wait_rx("rst_mid", 6);
        #2 rst_n = 1'b0;
        target_ok = 1'b0;
        #1;
        check("rst_mid_transmit", 64'(transmit), 64'd0);
        check("rst_mid_busy",     64'(busy),     64'd0);
        check("rst_mid_seq",      64'(seq),      64'd0);
        check("rst_mid_tx_byte",  64'(tx_byte),  64'd0);
        repeat (15) @(posedge clk);
        #1;
        check("rst_mid_rx", 64'(rxq.size()), 64'd6);
        rxq.delete();
        rst_n = 1'b1;
        glitch_done = 1'b1;
        glitch_width = 16'hA55A;
        @(posedge clk);
        #1 glitch_done = 1'b0;
        target_ok = 1'b1;
        check("rst_first_edge_busy", 64'(busy), 64'd1);
        collect("post_rst", got);
        check("post_rst_frame", got, 64'hA500A55A_010002FC);

        // 257 frames: seq field walks 1..255 then wraps to 0, 1
        for (int i = 0; i < 257; i++) begin
            run_start(16'(i), 0);
            collect($sformatf("wrap%0d", i), got);
            check($sformatf("wrap%0d_seq", i), 64'(got[55:48]), 64'((i + 1) % 256));
            if (i == 255) check("wrap_frame", got, 64'hA50000FF_010002FC);
        end
        check("wrap_final_seq", 64'(seq), 64'd2);

        repeat (5) @(posedge clk);
        #1;
        check("protocol_violations", 64'(viol), 64'd0);
        check("strobe_total", 64'(strobes), 64'd2126);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_report_tx.md
GLITCH_REPORT_TX -- requirements
Module: glitch_report_tx

Interface
REQ-001 Parameter HEADER, default 8'hA5: first byte of every report frame.
REQ-002 Parameter TIMEOUT, default 16'd60000: clk cycles to wait for a target response before reporting no-response.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 glitch_done  input  1  one-cycle pulse; the glitch pulse has just ended.
REQ-006 glitch_width  input  16  glitch duration used; valid in the cycle glitch_done is high.
REQ-007 target_ok  input  1  asynchronous target success pin; high means the target responded.
REQ-008 tx_busy  input  1  UART core is_transmitting; high while a byte is being shifted out.
REQ-009 transmit  output  1  one-cycle strobe to the UART core requesting transmission of tx_byte.
REQ-010 tx_byte  output  8  byte presented to the UART core; stable from the strobe until tx_busy falls.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 seq  output  8  sequence number of the next frame.

Function
REQ-013 target_ok SHALL pass through a two-flop synchronizer; all uses refer to the synchronized value ok_s.
REQ-014 States SHALL be IDLE, MEASURE, LOAD, STROBE, WAIT_ACK and WAIT_DONE.
REQ-015 IDLE: on glitch_done, latch glitch_width, clear the 16-bit latency counter and the overrun flag, and go to MEASURE.
REQ-016 MEASURE: if ok_s is high, set status bit0=1 and go to LOAD; else if latency == TIMEOUT, set status bit0=0 and go to LOAD; else increment latency.
REQ-017 ok_s high in the first MEASURE cycle SHALL report latency 0.
REQ-018 On timeout, latency SHALL report exactly TIMEOUT and never wrap.
REQ-019 A frame SHALL be 8 bytes in this order: HEADER, seq, width[15:8], width[7:0], status, latency[15:8], latency[7:0], checksum.
REQ-020 checksum SHALL be the XOR of bytes 1 through 6; HEADER is excluded.
REQ-021 status SHALL be {overrun, 6'b0, ok}.
REQ-022 LOAD: drive tx_byte with the byte at the 3-bit index, then go to STROBE.
REQ-023 STROBE: assert transmit for exactly one cycle, then go to WAIT_ACK.
REQ-024 WAIT_ACK: hold until tx_busy is high, then go to WAIT_DONE.
REQ-025 WAIT_DONE: hold until tx_busy is low.
REQ-026 At the end of WAIT_DONE: if index < 7, increment index and go to LOAD.
REQ-027 At the end of WAIT_DONE with index == 7: increment seq, clear index and go to IDLE.
REQ-028 seq SHALL wrap from 255 to 0.
REQ-029 glitch_done while busy SHALL be ignored for measurement and SHALL set the overrun flag.
REQ-030 If the overrun flag is set by the time status is sent (byte 4), status bit7 SHALL be 1 in that frame.
REQ-031 If overrun occurs after byte 4 is sent, the flag SHALL be discarded and the frame's status is unchanged.
REQ-032 glitch_done in the same cycle the FSM returns to IDLE SHALL be ignored; a new frame starts only from IDLE.
REQ-033 transmit SHALL never be high in consecutive cycles.
REQ-034 At most one transmit strobe SHALL occur per tx_busy high period.

Reset
REQ-035 On rst_n low, immediately and asynchronously: state=IDLE, transmit=0, tx_byte=0, busy=0, seq=0, index=0, latency=0, overrun=0, synchronizer flops=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame; no further strobes until a new glitch_done after reset release.
REQ-037 The first glitch_done is accepted on the first clk edge after rst_n rises.

Verification
REQ-038 glitch_width=16'h1234, target_ok rises 100 cycles after glitch_done, UART model with tx_busy 2 cycles after strobe for 10 cycles -> frame A5 00 12 34 01 00 xx yy plus checksum, where latency = 100 + synchronizer delay (exact value checked by the bench); seq becomes 1.
REQ-039 target_ok held low, TIMEOUT=16'd50 -> status 00, latency 00 32, checksum = 00^12^34^00^00^32.
REQ-040 target_ok already high at glitch_done -> latency counts only synchronizer delay (2); status 01.
REQ-041 Second glitch_done during byte 2 -> current frame status 81, no second frame; glitch_done after byte 5 -> status unchanged.
REQ-042 Run 257 frames -> seq field 255 then 0; transmit is never high in two consecutive cycles.
REQ-043 rst_n pulsed low during byte 5 -> transmit stays 0, busy=0, seq=0; next glitch_done yields a full frame with seq 00.
